// File: rtl/blram_dp.sv
// blram_dp: true dual-port block RAM with per-byte writes, deterministic same-address arbitration and optional clear after reset.
// Latency: RD_LAT (1 or 2) cycles from request to x_dout/x_vld, fully pipelined (one request per port per cycle).
// Backpressure: none; requests are accepted every cycle while ready is high and silently ignored while it is low.
module blram_dp #(
  parameter int SIZE       = 14,
  parameter int DEPTH      = 1024,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int WR_MODE    = 0,
  parameter int CLR_ON_RST = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_en,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [SIZE-1:0]     a_addr,
  input  logic [DATA_W-1:0]   a_din,
  output logic [DATA_W-1:0]   a_dout,
  output logic                a_vld,
  input  logic                b_en,
  input  logic                b_we,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [SIZE-1:0]     b_addr,
  input  logic [DATA_W-1:0]   b_din,
  output logic [DATA_W-1:0]   b_dout,
  output logic                b_vld,
  output logic                ready,
  output logic                collision
);
  localparam int NB = DATA_W / 8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [1:0]        state;
  logic [AW-1:0]     clr_cnt;
  logic              run;
  logic              a_act, b_act, a_inr, b_inr, a_wre, b_wre;
  logic              same_addr, a_wr, b_wr, coll_now;
  logic [AW-1:0]     a_idx, b_idx;
  logic [DATA_W-1:0] a_old, b_old, a_fin, b_fin, a_rd, b_rd;

  // Overlay the enabled bytes of din onto old.
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] din,
                                              input logic [NB-1:0]     be);
    logic [DATA_W-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) r[i*8 +: 8] = din[i*8 +: 8];
    end
    return r;
  endfunction

  assign run   = (state == ST_RUN);
  assign ready = run;

  // A request is live only in RUN and never on a reset edge.
  assign a_act     = a_en & run & ~rst;
  assign b_act     = b_en & run & ~rst;
  assign a_inr     = 32'(a_addr) < 32'(DEPTH);
  assign b_inr     = 32'(b_addr) < 32'(DEPTH);
  assign a_idx     = a_addr[AW-1:0];
  assign b_idx     = b_addr[AW-1:0];
  assign a_wre     = a_we & (|a_be);
  assign b_wre     = b_we & (|b_be);
  assign same_addr = (a_addr == b_addr);
  assign a_wr      = a_act & a_wre & a_inr;
  // Port A owns the word when both ports write the same address.
  assign b_wr      = b_act & b_wre & b_inr & ~(a_act & a_wre & same_addr);
  assign coll_now  = a_act & b_act & same_addr & (a_wre | b_wre);

  // Read path: old word, and the word as it will look after this cycle's writes from both ports.
  always_comb begin
    a_old = a_inr ? mem[a_idx] : '0;
    b_old = b_inr ? mem[b_idx] : '0;
    a_fin = a_old;
    if (a_wr)              a_fin = merge(a_fin, a_din, a_be);
    if (b_wr && same_addr) a_fin = merge(a_fin, b_din, b_be);
    b_fin = b_old;
    if (a_wr && same_addr) b_fin = merge(b_fin, a_din, a_be);
    if (b_wr)              b_fin = merge(b_fin, b_din, b_be);
    a_rd = (WR_MODE != 0) ? a_fin : a_old;
    b_rd = (WR_MODE != 0) ? b_fin : b_old;
  end

  // Array update: clear sequencer owns the array during CLEAR, otherwise the two ports; rst leaves contents alone.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      if (a_wr) mem[a_idx] <= merge(mem[a_idx], a_din, a_be);
      if (b_wr) mem[b_idx] <= merge(mem[b_idx], b_din, b_be);
    end
  end

  // Sequencer: RESET -> (CLEAR ->) RUN; the counter stops at DEPTH-1 so non-power-of-2 depths end exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RESET;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_RESET: begin
          clr_cnt <= '0;
          state   <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
        end
        ST_CLEAR: begin
          if (clr_cnt == AW'(DEPTH - 1)) state <= ST_RUN;
          else                           clr_cnt <= clr_cnt + 1'b1;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Collision flag is a registered one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) collision <= 1'b0;
    else     collision <= coll_now;
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              s1_a_vld, s1_b_vld;
      logic [DATA_W-1:0] s1_a_dat, s1_b_dat;
      // Two-stage read: array read register, then output register; dout holds when nothing completes.
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_a_vld <= 1'b0;
          s1_b_vld <= 1'b0;
          s1_a_dat <= '0;
          s1_b_dat <= '0;
          a_vld    <= 1'b0;
          b_vld    <= 1'b0;
          a_dout   <= '0;
          b_dout   <= '0;
        end else begin
          s1_a_vld <= a_act;
          s1_b_vld <= b_act;
          if (a_act) s1_a_dat <= a_rd;
          if (b_act) s1_b_dat <= b_rd;
          a_vld <= s1_a_vld;
          b_vld <= s1_b_vld;
          if (s1_a_vld) a_dout <= s1_a_dat;
          if (s1_b_vld) b_dout <= s1_b_dat;
        end
      end
    end else begin : g_lat1
      // Single-stage read straight into the output register; dout holds when nothing completes.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_vld  <= 1'b0;
          b_vld  <= 1'b0;
          a_dout <= '0;
          b_dout <= '0;
        end else begin
          a_vld <= a_act;
          b_vld <= b_act;
          if (a_act) a_dout <= a_rd;
          if (b_act) b_dout <= b_rd;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_blram_dp.sv
// Bench for blram_dp: three configurations driven by one shared stimulus stream,
// each compared every cycle against an array-based model of the memory's rules,
// plus a few hand-computed spot values from the directed scenarios.
module tb_blram_dp;
  logic        clk;
  logic        rst;
  logic        a_en, a_we, b_en, b_we;
  logic [3:0]  a_be, b_be;
  logic [13:0] a_addr, b_addr;
  logic [31:0] a_din, b_din;

  logic [31:0] a_dout_w [3];
  logic [31:0] b_dout_w [3];
  logic        a_vld_w  [3];
  logic        b_vld_w  [3];
  logic        rdy_w    [3];
  logic        coll_w   [3];

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 0;

  // Per-instance configuration mirrored in the model.
  int dep [3] = '{1024, 1000, 64};
  int lat [3] = '{1, 2, 2};
  int wm  [3] = '{0, 1, 0};
  int clr [3] = '{0, 0, 1};

  // Reference model state.
  logic [31:0] mm   [3][1024];
  bit          pv   [3][2][8];
  logic [31:0] pd   [3][2][8];
  bit          ev   [3][2];
  logic [31:0] ed   [3][2];
  bit          ecoll[3];
  bit          erdy [3];
  int          rel  [3];
  int          cyc = 0;

  blram_dp #(.SIZE(14), .DEPTH(1024), .DATA_W(32), .RD_LAT(1), .WR_MODE(0), .CLR_ON_RST(0)) u0 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout_w[0]), .a_vld(a_vld_w[0]),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout_w[0]), .b_vld(b_vld_w[0]),
    .ready(rdy_w[0]), .collision(coll_w[0]));

  blram_dp #(.SIZE(14), .DEPTH(1000), .DATA_W(32), .RD_LAT(2), .WR_MODE(1), .CLR_ON_RST(0)) u1 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout_w[1]), .a_vld(a_vld_w[1]),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout_w[1]), .b_vld(b_vld_w[1]),
    .ready(rdy_w[1]), .collision(coll_w[1]));

  blram_dp #(.SIZE(14), .DEPTH(64), .DATA_W(32), .RD_LAT(2), .WR_MODE(0), .CLR_ON_RST(1)) u2 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout_w[2]), .a_vld(a_vld_w[2]),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout_w[2]), .b_vld(b_vld_w[2]),
    .ready(rdy_w[2]), .collision(coll_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] din, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = din[8*i +: 8];
    return r;
  endfunction

  // One clock edge of the memory's behaviour for instance d.
  task automatic model_step(input int d);
    logic [31:0] olda, oldb, ra, rb;
    bit ina, inb, wa, wb, same, coll;
    int ia, ib, ss, thr;
    thr = (clr[d] != 0) ? dep[d] + 1 : 1;
    if (rst) begin
      rel[d] = 0;
      for (int s = 0; s < 8; s++) begin pv[d][0][s] = 0; pv[d][1][s] = 0; end
      ev[d][0] = 0; ev[d][1] = 0; ed[d][0] = 0; ed[d][1] = 0;
      ecoll[d] = 0; erdy[d] = 0;
      return;
    end
    coll = 0;
    if (rel[d] >= thr) begin
      ia = int'(a_addr); ib = int'(b_addr);
      ina = ia < dep[d]; inb = ib < dep[d];
      wa = a_we && (a_be != 4'h0); wb = b_we && (b_be != 4'h0);
      same = (ia == ib);
      coll = a_en && b_en && same && (wa || wb);
      olda = 0; oldb = 0;
      if (ina) olda = mm[d][ia];
      if (inb) oldb = mm[d][ib];
      if (a_en && wa && ina) mm[d][ia] = bmerge(mm[d][ia], a_din, a_be);
      if (b_en && wb && inb && !(a_en && wa && same)) mm[d][ib] = bmerge(mm[d][ib], b_din, b_be);
      ss = (cyc + lat[d] - 1) % 8;
      if (a_en) begin
        ra = 0;
        if (ina) ra = (wm[d] != 0) ? mm[d][ia] : olda;
        pv[d][0][ss] = 1; pd[d][0][ss] = ra;
      end
      if (b_en) begin
        rb = 0;
        if (inb) rb = (wm[d] != 0) ? mm[d][ib] : oldb;
        pv[d][1][ss] = 1; pd[d][1][ss] = rb;
      end
    end
    ecoll[d] = coll;
    if (rel[d] < 100000) rel[d]++;
    if (clr[d] != 0 && rel[d] == thr) for (int i = 0; i < 1024; i++) mm[d][i] = 0;
    erdy[d] = rel[d] >= thr;
    ss = cyc % 8;
    for (int p = 0; p < 2; p++) begin
      if (pv[d][p][ss]) begin ev[d][p] = 1; ed[d][p] = pd[d][p][ss]; pv[d][p][ss] = 0; end
      else ev[d][p] = 0;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 3; d++) model_step(d);
  end

  // Every cycle, away from the active edge, compare all outputs of all instances with the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("u%0d_a_vld", d),  32'(a_vld_w[d]), 32'(ev[d][0]));
        chk($sformatf("u%0d_b_vld", d),  32'(b_vld_w[d]), 32'(ev[d][1]));
        chk($sformatf("u%0d_a_dout", d), a_dout_w[d], ed[d][0]);
        chk($sformatf("u%0d_b_dout", d), b_dout_w[d], ed[d][1]);
        chk($sformatf("u%0d_ready", d),  32'(rdy_w[d]), 32'(erdy[d]));
        chk($sformatf("u%0d_coll", d),   32'(coll_w[d]), 32'(ecoll[d]));
      end
    end
  end

  task automatic idle();
    a_en = 0; a_we = 0; a_be = 4'h0; a_addr = '0; a_din = '0;
    b_en = 0; b_we = 0; b_be = 4'h0; b_addr = '0; b_din = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_a(input logic we, input logic [3:0] be, input int addr, input logic [31:0] din);
    a_en = 1; a_we = we; a_be = be; a_addr = 14'(addr); a_din = din;
  endtask

  task automatic set_b(input logic we, input logic [3:0] be, input int addr, input logic [31:0] din);
    b_en = 1; b_we = we; b_be = be; b_addr = 14'(addr); b_din = din;
  endtask

  // Addresses clustered to provoke collisions and every instance's depth boundary.
  function automatic int pick_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 5)  return int'($urandom_range(0, 7));
    if (r == 6)  return int'($urandom_range(56, 71));
    if (r == 7)  return int'($urandom_range(990, 1009));
    if (r == 8)  return int'($urandom_range(1016, 1031));
    return 16383;
  endfunction

  initial begin
    int k;
    for (int d = 0; d < 3; d++) begin
      rel[d] = 0;
      for (int i = 0; i < 1024; i++) mm[d][i] = 0;
    end
    rst = 1;
    idle();
    repeat (3) step();
    chk_on = 1;
    step();
    rst = 0;

    // Preload every address the random phase can touch, plus the directed ones.
    for (int i = 0; i < 32; i++)     begin set_a(1, 4'hF, i, $urandom); step(); end
    for (int i = 56; i < 72; i++)    begin set_a(1, 4'hF, i, $urandom); step(); end
    for (int i = 990; i < 1032; i++) begin set_a(1, 4'hF, i, $urandom); step(); end
    set_a(1, 4'hF, 100, 32'd6); step();

    // Preload readback: one cycle on u0, two cycles on u1.
    set_a(0, 4'h0, 100, 0); step();
    chk("rd100_u0_vld", 32'(a_vld_w[0]), 32'd1);
    chk("rd100_u0_dat", a_dout_w[0], 32'd6);
    idle(); step();
    chk("rd100_u1_dat", a_dout_w[1], 32'd6);

    // Byte-enable merge.
    set_a(1, 4'hF, 5, 32'h11223344); step();
    set_a(1, 4'b0101, 5, 32'hAABBCCDD); step();
    set_a(0, 4'h0, 5, 0); step();
    chk("bemerge_u0", a_dout_w[0], 32'h11BB33DD);
    idle(); step();

    // Read-during-write: read-first on u0, write-first on u1.
    set_a(1, 4'hF, 7, 32'h9); step();
    set_a(1, 4'hF, 7, 32'h55); step();
    chk("rdw_first_u0", a_dout_w[0], 32'h9);
    idle(); step();
    chk("wr_first_u1", a_dout_w[1], 32'h55);

    // Collisions: write/write then write/read.
    set_a(1, 4'hF, 20, 32'h1); set_b(1, 4'hF, 20, 32'h2); step();
    chk("coll_ww_pulse", 32'(coll_w[0]), 32'd1);
    idle(); step();
    chk("coll_ww_end", 32'(coll_w[0]), 32'd0);
    set_a(0, 4'h0, 20, 0); set_b(0, 4'h0, 20, 0); step();
    chk("coll_ww_a", a_dout_w[0], 32'h1);
    chk("coll_ww_b", b_dout_w[0], 32'h1);
    set_a(1, 4'hF, 20, 32'h77); set_b(0, 4'h0, 20, 0); step();
    chk("coll_wr_pulse", 32'(coll_w[0]), 32'd1);
    chk("coll_wr_b_u0", b_dout_w[0], 32'h1);
    idle(); step();
    chk("coll_wr_b_u1", b_dout_w[1], 32'h77);

    // Out of range on port B must not alias onto a low address.
    set_a(1, 4'hF, 6, 32'h1234); step();
    set_b(1, 4'hF, 1030, 32'hFFFF); idle(); set_b(1, 4'hF, 1030, 32'hFFFF); step();
    set_a(0, 4'h0, 6, 0); set_b(0, 4'h0, 1030, 0); step();
    chk("oor_alias", a_dout_w[0], 32'h1234);
    chk("oor_rd_dat", b_dout_w[0], 32'h0);
    chk("oor_rd_vld", 32'(b_vld_w[0]), 32'd1);
    idle(); step();

    // Random traffic on both ports.
    for (int n = 0; n < 1500; n++) begin
      a_en = ($urandom_range(0, 3) != 0); a_we = 1'($urandom); a_be = 4'($urandom);
      a_addr = 14'(pick_addr()); a_din = $urandom;
      b_en = ($urandom_range(0, 3) != 0); b_we = 1'($urandom); b_be = 4'($urandom);
      b_addr = 14'(pick_addr()); b_din = $urandom;
      step();
    end
    idle(); step();

    // Reset with reads in flight, then requests during CLEAR, then a reset mid-CLEAR.
    set_a(1, 4'hF, 63, 32'h3E8); step();
    set_a(0, 4'h0, 63, 0); set_b(0, 4'h0, 20, 0); step();
    idle(); rst = 1; step(); step();
    rst = 0;
    for (int n = 0; n < 30; n++) begin set_a(0, 4'h0, 63, 0); step(); end
    idle(); rst = 1; step();
    rst = 0;
    k = 0;
    while (rdy_w[2] !== 1'b1 && k < 200) begin step(); k++; end
    chk("clr_len_u2", 32'(k), 32'd65);
    set_a(0, 4'h0, 63, 0); step();
    idle(); step();
    chk("clr_mem63_u2", a_dout_w[2], 32'h0);
    repeat (3) step();

    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/blram_dp.md
# blram_dp

Parametrised true dual-port successor to the single-port block RAM used by the VerySimpleCPU benches. Port A serves the CPU core; port B serves a second master (loader, debug reader, DMA). Adds:
- per-byte write enables
- selectable read latency and read-during-write mode
- deterministic collision arbitration
- an optional post-reset clear sequencer with a `ready` handshake

## Interface
- `SIZE`, 14, address width of both ports
- `DEPTH`, 1024, number of words; legal addresses 0..DEPTH-1
- `DATA_W`, 32, word width; must be a multiple of 8
- `RD_LAT`, 1, read latency in cycles; legal values 1 or 2
- `WR_MODE`, 0, 0 = read-first (old data returned), 1 = write-first (new data returned)
- `CLR_ON_RST`, 0, 1 = zero the whole array after every reset

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `a_en` in 1: port A request
- `a_we` in 1: port A write (qualified by `a_en`)
- `a_be` in DATA_W/8: port A byte enables
- `a_addr` in SIZE: port A address
- `a_din` in DATA_W: port A write data
- `a_dout` out DATA_W: port A read data
- `a_vld` out 1: `a_dout` updated this cycle
- `b_en`, `b_we`, `b_be`, `b_addr`, `b_din`, `b_dout`, `b_vld`: port B, identical to port A
- `ready` out 1: array usable; requests ignored while low
- `collision` out 1: one-cycle pulse flagging a same-address conflict

## Operation
- Memory contents are not touched by `rst`. Only `CLR_ON_RST=1` clears them. Initial-block preload remains valid when `CLR_ON_RST=0`.
- Every enabled request performs a read, including writes. Data returns on `x_dout` with `x_vld=1` after RD_LAT cycles.
- `x_dout` holds its last value when no read completes.
- Writes update only bytes with `x_be[i]=1`. `x_we=1` with `x_be=0` is a read.
- `WR_MODE=0`: a write returns the pre-write word. `WR_MODE=1`: a write returns the merged post-write word.
- Address ≥ DEPTH: the write is dropped, the read returns 0, and `x_vld` still pulses.
- Collision: both ports enabled, same address, at least one writing. Rules:
  - A's write always lands.
  - If both write, B's write is dropped entirely.
  - B's read follows WR_MODE relative to A's write.
  - `collision` pulses one cycle after the request cycle.
  - Two reads to the same address is not a collision.
- Clear sequencer states:
  - RESET: while `rst`.
  - RESET → CLEAR: if `CLR_ON_RST=1`.
  - RESET → RUN: if `CLR_ON_RST=0`.
  - CLEAR: writes 0 to address k on cycle k, k = 0..DEPTH-1. Port enables are masked, and no `x_vld` or `collision` is produced.
  - CLEAR → RUN: after address DEPTH-1 is written.
  - RUN: normal operation.

## Timing
- Reset values: `a_dout`=`b_dout`=0, `a_vld`=`b_vld`=0, `ready`=0, `collision`=0. All pipeline stages are flushed.
- `ready` rises:
  - `CLR_ON_RST=0`: on the first edge with `rst` low.
  - `CLR_ON_RST=1`: DEPTH cycles after that edge.
- RD_LAT=1: request on edge n, data on edge n+1 (same as current blram).
- RD_LAT=2: data on edge n+2 through an extra output register. Back-to-back requests every cycle give full throughput.
- A write is visible to a read issued on the next cycle, on either port.
- `rst` asserted mid-CLEAR: the counter restarts at 0 after release.
- `rst` asserted with reads in flight: the reads are discarded and no `x_vld` follows.
- The clear counter does not wrap. A terminal count of exactly DEPTH-1 ends CLEAR, including when DEPTH is not a power of 2.

## Test plan
- **Preload readback.** Preload mem[100]=6, RD_LAT=1, A reads addr 100 → `a_dout`=6, `a_vld`=1 exactly one cycle later. Repeat with RD_LAT=2 → same data two cycles later.
- **Byte-enable merge.** Start with mem[5]=0x11223344. A writes 0xAABBCCDD with `a_be`=4'b0101, then reads addr 5 → 0x11BB33DD.
- **Read-during-write mode.**
  - WR_MODE=0: A writes 0x55 to addr 7 (old value 0x9) → `a_dout`=0x9.
  - WR_MODE=1: same write → `a_dout`=0x55.
- **Collision.** Same cycle, A writes 0x1 and B writes 0x2 to addr 20 → `collision`=1 for one cycle; a later read of addr 20 on either port → 0x1. A write vs B read on the same address → `collision`=1, B data per WR_MODE.
- **Out of range.** DEPTH=1024, B writes 0xFFFF to addr 1030 → mem[6] unchanged; reading addr 1030 → 0 with `b_vld`=1.
- **Clear sequencer.** CLR_ON_RST=1, DEPTH=64, preload mem[63]=0x3E8:
  - Release `rst` → `ready` rises after 64 cycles; requests during CLEAR produce no `a_vld`; mem[63] then reads 0.
  - Re-assert `rst` at cycle 30 of CLEAR → a full 64-cycle clear follows the release.
